input_debounce_conditioner: RTL

//  Upstream conditioning stage for the 4-input priority encoder. It synchronises raw

---
 rtl/input_debounce_conditioner_if.sv | 29 ++
 rtl/input_debounce_conditioner.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/input_debounce_conditioner_if.sv
// Port bundle between the raw request lines, the debounce conditioner and
// its consumers (the 4-input priority encoder and event-driven logic).
// There is no valid/ready handshake here: every signal is a continuous level
// (d_rise/d_fall are single-cycle pulses), sampled on the rising clock edge.
// state_dbg exposes each channel's FSM state, 2 bits per channel, channel i
// at [2*i+1:2*i]; encoding LOW=0, CHK_H=1, HIGH=2, CHK_L=3.
interface input_debounce_conditioner_if #(
   parameter int N_CH = 4
);
   logic              en;
   logic [N_CH-1:0]   d_raw;
   logic [N_CH-1:0]   d_stable;
   logic [N_CH-1:0]   d_rise;
   logic [N_CH-1:0]   d_fall;
   logic              any_active;
   logic [2*N_CH-1:0] state_dbg;

   // Upstream side: drives raw lines and enable, observes conditioned levels.
   modport master (
      output en, d_raw,
      input  d_stable, d_rise, d_fall, any_active, state_dbg
   );

   // Conditioner side.
   modport slave (
      input  en, d_raw,
      output d_stable, d_rise, d_fall, any_active, state_dbg
   );
endinterface

// File: rtl/input_debounce_conditioner.sv
// Synchronises and independently debounces N_CH raw request lines. Each
// channel runs a four-state FSM (LOW, CHK_H, HIGH, CHK_L) with a saturating
// qualification counter; a change is accepted only after DB_CYCLES identical
// synchronised samples, counted from the most recent bounce.
module input_debounce_conditioner #(
   parameter int N_CH        = 4,
   parameter int SYNC_STAGES = 2,
   parameter int DB_CYCLES   = 8
) (
   input logic                        clk,
   input logic                        rst_n,
   input_debounce_conditioner_if.slave bus
);

   localparam int            CW       = $clog2(DB_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   typedef enum logic [1:0] {
      LOW   = 2'd0,
      CHK_H = 2'd1,
      HIGH  = 2'd2,
      CHK_L = 2'd3
   } state_e;

   logic [N_CH-1:0] sync_q [SYNC_STAGES];
   logic [N_CH-1:0] s;

   state_e          state_q [N_CH];
   state_e          state_d [N_CH];
   logic [CW-1:0]   cnt_q   [N_CH];
   logic [CW-1:0]   cnt_d   [N_CH];

   logic [N_CH-1:0] stable_q, stable_d;
   logic [N_CH-1:0] rise_q, rise_d;
   logic [N_CH-1:0] fall_q, fall_d;

   // Synchroniser chain: runs every cycle, independent of en.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      end else begin
         sync_q[0] <= bus.d_raw;
         for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      end
   end

   assign s = sync_q[SYNC_STAGES-1];

   // Per-channel next state, counter and output pulses; en=0 freezes all of it.
   always_comb begin
      for (int i = 0; i < N_CH; i++) begin
         state_d[i] = state_q[i];
         cnt_d[i]   = cnt_q[i];
      end
      stable_d = stable_q;
      rise_d   = '0;
      fall_d   = '0;

      if (bus.en) begin
         for (int i = 0; i < N_CH; i++) begin
            unique case (state_q[i])
               LOW: begin
                  if (s[i]) begin
                     if (DB_CYCLES == 1) begin
                        state_d[i]  = HIGH;
                        cnt_d[i]    = '0;
                        stable_d[i] = 1'b1;
                        rise_d[i]   = 1'b1;
                     end else begin
                        state_d[i] = CHK_H;
                        cnt_d[i]   = CNT_ONE;
                     end
                  end
               end
               CHK_H: begin
                  if (!s[i]) begin
                     // Bounce: fall back to the settled level and restart.
                     state_d[i] = LOW;
                     cnt_d[i]   = '0;
                  end else if (cnt_q[i] == CNT_LAST) begin
                     state_d[i]  = HIGH;
                     cnt_d[i]    = '0;
                     stable_d[i] = 1'b1;
                     rise_d[i]   = 1'b1;
                  end else begin
                     cnt_d[i] = cnt_q[i] + CNT_ONE;
                  end
               end
               HIGH: begin
                  if (!s[i]) begin
                     if (DB_CYCLES == 1) begin
                        state_d[i]  = LOW;
                        cnt_d[i]    = '0;
                        stable_d[i] = 1'b0;
                        fall_d[i]   = 1'b1;
                     end else begin
                        state_d[i] = CHK_L;
                        cnt_d[i]   = CNT_ONE;
                     end
                  end
               end
               CHK_L: begin
                  if (s[i]) begin
                     state_d[i] = HIGH;
                     cnt_d[i]   = '0;
                  end else if (cnt_q[i] == CNT_LAST) begin
                     state_d[i]  = LOW;
                     cnt_d[i]    = '0;
                     stable_d[i] = 1'b0;
                     fall_d[i]   = 1'b1;
                  end else begin
                     cnt_d[i] = cnt_q[i] + CNT_ONE;
                  end
               end
               default: begin
                  state_d[i] = LOW;
                  cnt_d[i]   = '0;
               end
            endcase
         end
      end
   end

   // State, counter and registered outputs; reset discards any pending change.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_CH; i++) begin
            state_q[i] <= LOW;
            cnt_q[i]   <= '0;
         end
         stable_q <= '0;
         rise_q   <= '0;
         fall_q   <= '0;
      end else begin
         for (int i = 0; i < N_CH; i++) begin
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
         end
         stable_q <= stable_d;
         rise_q   <= rise_d;
         fall_q   <= fall_d;
      end
   end

   assign bus.d_stable   = stable_q;
   assign bus.d_rise     = rise_q;
   assign bus.d_fall     = fall_q;
   assign bus.any_active = |stable_q;

   // Pack per-channel FSM state for observation.
   always_comb begin
      bus.state_dbg = '0;
      for (int i = 0; i < N_CH; i++) bus.state_dbg[2*i +: 2] = state_q[i];
   end

endmodule
